// File: rtl/mips_stall_pkg.sv
// Shared types and constants for the MIPS pipeline stall controller:
// FSM states, stall-cause encoding and default opcode decode constants.
package mips_stall_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD_ST  = 2'd1,
    JMP_ST = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_LD   = 2'd1;
  localparam logic [1:0] K_JMP  = 2'd2;
  localparam logic [1:0] K_HLT  = 2'd3;

  localparam logic [5:0] DEF_OP_HLT    = 6'b010001;
  localparam logic [5:0] DEF_OP_LD     = 6'b010100;
  localparam logic [5:0] DEF_JMP_MASK  = 6'b111100;
  localparam logic [5:0] DEF_JMP_MATCH = 6'b011100;

endpackage

// File: rtl/pipeline_stall_decode.sv
// Combinational opcode matcher for the stall controller; reports at most one
// hit, with halt taking precedence over jump and jump over load.
module pipeline_stall_decode
  import mips_stall_pkg::*;
#(
  parameter int             OP_W      = 6,
  parameter logic [OP_W-1:0] OP_HLT    = DEF_OP_HLT,
  parameter logic [OP_W-1:0] OP_LD     = DEF_OP_LD,
  parameter logic [OP_W-1:0] JMP_MASK  = DEF_JMP_MASK,
  parameter logic [OP_W-1:0] JMP_MATCH = DEF_JMP_MATCH
) (
  input  logic [OP_W-1:0] op,
  input  logic            op_valid,
  output logic            hit_hlt,
  output logic            hit_jmp,
  output logic            hit_ld
);

  logic raw_hlt_s;
  logic raw_jmp_s;
  logic raw_ld_s;

  // Raw matches, then priority resolution so callers never see two hits.
  always_comb begin
    raw_hlt_s = op_valid & (op == OP_HLT);
    raw_jmp_s = op_valid & ((op & JMP_MASK) == JMP_MATCH);
    raw_ld_s  = op_valid & (op == OP_LD);
    hit_hlt   = raw_hlt_s;
    hit_jmp   = raw_jmp_s & ~raw_hlt_s;
    hit_ld    = raw_ld_s & ~raw_hlt_s & ~raw_jmp_s;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: decodes the ID opcode and holds PC/IF-ID for
// load-use, jump and halt, with a one-cycle-delayed hold for program memory.
module pipeline_stall_ctrl
  import mips_stall_pkg::*;
#(
  parameter int              OP_W             = 6,
  parameter int              CNT_W            = 4,
  parameter int              LD_STALL_CYCLES  = 1,
  parameter int              JMP_STALL_CYCLES = 2,
  parameter logic [OP_W-1:0] OP_HLT           = DEF_OP_HLT,
  parameter logic [OP_W-1:0] OP_LD            = DEF_OP_LD,
  parameter logic [OP_W-1:0] JMP_MASK         = DEF_JMP_MASK,
  parameter logic [OP_W-1:0] JMP_MATCH        = DEF_JMP_MATCH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            op_valid,
  input  logic            resume,
  output logic            stall,
  output logic            stall_pm,
  output logic            halted,
  output logic [1:0]      kind
);

  localparam int CNT_MAX = (32'sd1 <<< CNT_W) - 32'sd1;

  if (LD_STALL_CYCLES < 32'sd1 || LD_STALL_CYCLES > CNT_MAX) begin : g_bad_ld
    $error("LD_STALL_CYCLES out of range for CNT_W");
  end
  if (JMP_STALL_CYCLES < 32'sd1 || JMP_STALL_CYCLES > CNT_MAX) begin : g_bad_jmp
    $error("JMP_STALL_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LD_LOAD  = CNT_W'(LD_STALL_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] JMP_LOAD = CNT_W'(JMP_STALL_CYCLES - 32'sd1);
  localparam bit LD_SINGLE  = (LD_STALL_CYCLES == 32'sd1);
  localparam bit JMP_SINGLE = (JMP_STALL_CYCLES == 32'sd1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             stall_pm_r;
  logic             stall_s;
  logic [1:0]       kind_s;
  logic             dec_valid_s;
  logic             hit_hlt_s;
  logic             hit_jmp_s;
  logic             hit_ld_s;

  // op only counts while IDLE; in any held state it is ignored.
  assign dec_valid_s = op_valid & (state_r == IDLE);

  pipeline_stall_decode #(
    .OP_W      (OP_W),
    .OP_HLT    (OP_HLT),
    .OP_LD     (OP_LD),
    .JMP_MASK  (JMP_MASK),
    .JMP_MATCH (JMP_MATCH)
  ) u_decode (
    .op       (op),
    .op_valid (dec_valid_s),
    .hit_hlt  (hit_hlt_s),
    .hit_jmp  (hit_jmp_s),
    .hit_ld   (hit_ld_s)
  );

  // Next-state, counter and stall/kind generation.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    kind_s      = K_NONE;
    case (state_r)
      IDLE: begin
        if (hit_hlt_s) begin
          stall_s     = 1'b1;
          kind_s      = K_HLT;
          state_nxt_s = HALT;
        end else if (hit_jmp_s) begin
          stall_s = 1'b1;
          kind_s  = K_JMP;
          if (JMP_SINGLE) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = JMP_ST;
            cnt_nxt_s   = JMP_LOAD;
          end
        end else if (hit_ld_s) begin
          stall_s = 1'b1;
          kind_s  = K_LD;
          if (LD_SINGLE) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = LD_ST;
            cnt_nxt_s   = LD_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LD_ST, JMP_ST: begin
        stall_s = 1'b1;
        kind_s  = (state_r == LD_ST) ? K_LD : K_JMP;
        // The decode cycle already counted as one stall cycle.
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      HALT: begin
        stall_s = 1'b1;
        kind_s  = K_HLT;
        if (resume) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and program-memory hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      stall_pm_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      stall_pm_r <= stall_s;
    end
  end

  assign stall    = stall_s & ~reset;
  assign kind     = reset ? K_NONE : kind_s;
  assign stall_pm = stall_pm_r;
  assign halted   = (state_r == HALT);

endmodule
